// File: rtl/thermo_mult_pipe.sv
// thermo_mult_pipe
//   Signed thermometer-code multiplier with a two-stage valid/ready pipeline.
//   Each sample is scaled by a loadable weight: the result level is
//   round(a*s/W), where a and s are the sample and weight levels. Rounding is
//   ceiling when ROUND_MODE=0 and floor when ROUND_MODE=1.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   w_load, w_in        weight load strobe and code {sign, thermometer}
//   w_err               one-cycle pulse when a loaded weight code is rejected
//   weight_q            weight currently applied to new samples
//   in_valid, in_ready  sample handshake
//   in_data             sample code {sign, thermometer}
//   in_err              one-cycle pulse when an accepted sample is malformed
//   out_valid, out_ready, out_data   result handshake and code
module thermo_mult_pipe #(
  parameter int W          = 16,
  parameter int ROUND_MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         w_load,
  input  logic [W:0]   w_in,
  output logic         w_err,
  output logic [W:0]   weight_q,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   in_data,
  output logic         in_err,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_data
);

  localparam int LW = $clog2(W + 1);
  localparam int PW = 2 * LW;

  // Length of the run of ones starting at bit 0.
  function automatic logic [LW-1:0] level_of(input logic [W-1:0] x);
    logic [LW-1:0] n;
    logic          run;
    n   = '0;
    run = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      if (run && x[i]) n = LW'(i + 1);
      else             run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [W-1:0] thermo(input logic [LW-1:0] n);
    logic [W-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < W; i++) t[i] = (i < 32'(n));
    return t;
  endfunction

  function automatic logic code_ok(input logic [W-1:0] x);
    return thermo(level_of(x)) == x;
  endfunction

  logic          s1_valid;
  logic [LW-1:0] s1_lvl;
  logic          s1_sign;
  logic [LW-1:0] s1_wlvl;
  logic          s1_wsign;

  logic          s2_ready;
  logic          s1_adv;
  logic          accept;

  logic [PW-1:0] prod;
  logic [PW-1:0] quo;
  logic [LW-1:0] res_lvl;
  logic [W:0]    res_code;

  assign s2_ready = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    prod = PW'(s1_lvl) * PW'(s1_wlvl);
    if (ROUND_MODE == 0) quo = (prod + PW'(W - 1)) / PW'(W);
    else                 quo = prod / PW'(W);
    res_lvl           = LW'(quo);
    res_code          = '0;
    res_code[W-1:0]   = thermo(res_lvl);
    res_code[W]       = (res_lvl != '0) && (s1_sign ^ s1_wsign);
  end

  // Weight register; a sample accepted on the same edge as a load still
  // captures the old weight because stage 1 reads weight_q before the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q <= '0;
      w_err    <= 1'b0;
    end else begin
      w_err <= w_load && !code_ok(w_in[W-1:0]);
      if (w_load && code_ok(w_in[W-1:0])) weight_q <= w_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lvl   <= '0;
      s1_sign  <= 1'b0;
      s1_wlvl  <= '0;
      s1_wsign <= 1'b0;
      in_err   <= 1'b0;
    end else begin
      in_err <= accept && !code_ok(in_data[W-1:0]);
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_lvl   <= level_of(in_data[W-1:0]);
        s1_sign  <= in_data[W];
        s1_wlvl  <= level_of(weight_q[W-1:0]);
        s1_wsign <= weight_q[W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (s2_ready) out_valid <= s1_valid;
      if (s1_adv)   out_data  <= res_code;
    end
  end

endmodule

// File: tb/tb_thermo_mult_pipe.sv
module tb_thermo_mult_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         w_load;
  logic [W:0]   w_in;
  logic         in_valid;
  logic [W:0]   in_data;
  logic         out_ready;

  logic         w_err, in_err, in_ready, out_valid;
  logic [W:0]   weight_q, out_data;
  logic         w_err_f, in_err_f, in_ready_f, out_valid_f;
  logic [W:0]   weight_q_f, out_data_f;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  thermo_mult_pipe #(.W(W), .ROUND_MODE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_in(w_in), .w_err(w_err),
    .weight_q(weight_q), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_err(in_err), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  thermo_mult_pipe #(.W(W), .ROUND_MODE(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_in(w_in), .w_err(w_err_f),
    .weight_q(weight_q_f), .in_valid(in_valid), .in_ready(in_ready_f),
    .in_data(in_data), .in_err(in_err_f), .out_valid(out_valid_f),
    .out_ready(out_ready), .out_data(out_data_f)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int lvl(input logic [W-1:0] x);
    int n = 0;
    while (n < W && x[n]) n++;
    return n;
  endfunction

  function automatic bit tvalid(input logic [W-1:0] x);
    logic [W-1:0] ones = '1;
    int n = lvl(x);
    if (n == 0) return x == '0;
    return x == (ones >> (W - n));
  endfunction

  function automatic logic [W:0] enc(input int r, input logic sg);
    logic [W-1:0] ones = '1;
    logic [W:0]   v;
    v[W-1:0] = (r == 0) ? '0 : (ones >> (W - r));
    v[W]     = (r != 0) && sg;
    return v;
  endfunction

  typedef struct {
    logic [W:0] c;
    logic [W:0] f;
  } exp_t;

  exp_t       sbq[$];
  logic [W:0] mw;

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      mw = '0;
    end else begin
      chk("rounding_variants_in_step", {30'd0, out_valid_f, in_ready_f}, {30'd0, out_valid, in_ready});
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_out_ceil", 32'(out_data), 32'(e.c));
          chk("sb_out_floor", 32'(out_data_f), 32'(e.f));
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        int a, s, p, rc, rf;
        logic sg;
        a  = lvl(in_data[W-1:0]);
        s  = lvl(mw[W-1:0]);
        p  = a * s;
        rf = p / W;
        rc = rf + ((p % W) != 0 ? 1 : 0);
        sg = in_data[W] ^ mw[W];
        e.c = enc(rc, sg);
        e.f = enc(rf, sg);
        sbq.push_back(e);
      end
      if (w_load && tvalid(w_in[W-1:0])) mw = w_in;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input logic [W:0] w, input logic [W:0] d,
                         input logic [W:0] ec, input logic [W:0] ef);
    int n = 0;
    w_load = 1'b1; w_in = w;
    tick;
    w_load = 1'b0;
    in_valid = 1'b1; in_data = d;
    tick;
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin tick; n++; end
    if (!out_valid) chk("vec_timeout", 32'(out_valid), 32'd1);
    else begin
      chk("vec_ceil", 32'(out_data), 32'(ec));
      chk("vec_floor", 32'(out_data_f), 32'(ef));
    end
    tick;
  endtask

  // Collect n results in order; optionally drop in_valid after the first edge.
  task automatic collect(input string tag, input int n, input bit drop_first,
                         input logic [W:0] e0, input logic [W:0] e1, input logic [W:0] e2);
    logic [W:0] seq[3];
    int got = 0;
    seq[0] = e0; seq[1] = e1; seq[2] = e2;
    for (int k = 0; k < 20 && got < n; k++) begin
      if (out_valid) begin
        chk(tag, 32'(out_data), 32'(seq[got]));
        got++;
      end
      tick;
      if (k == 0 && drop_first) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk({tag, "_count"}, 32'(got), 32'(n));
  endtask

  typedef struct {
    logic [W:0] w;
    logic [W:0] d;
    logic [W:0] ec;
    logic [W:0] ef;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{17'h100FF, 17'h0001F, 17'h10007, 17'h10003};
    vecs[1] = '{17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF};
    vecs[2] = '{17'h0FFFF, 17'h1000F, 17'h1000F, 17'h1000F};
    vecs[3] = '{17'h00007, 17'h00003, 17'h00001, 17'h00000};
    vecs[4] = '{17'h1FFFF, 17'h1FFFF, 17'h0FFFF, 17'h0FFFF};
    vecs[5] = '{17'h10001, 17'h00000, 17'h00000, 17'h00000};
    vecs[6] = '{17'h000FF, 17'h0007F, 17'h0000F, 17'h00007};
    vecs[7] = '{17'h0FFFF, 17'h10001, 17'h10001, 17'h10001};
    vecs[8] = '{17'h00001, 17'h00001, 17'h00001, 17'h00000};

    rst_n = 1'b0; w_load = 1'b0; w_in = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_weight_q", 32'(weight_q), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_errs", {30'd0, w_err, in_err}, 32'd0);
    rst_n = 1'b1;

    // No weight loaded: level 10 sample scales to zero, two edges later.
    in_valid = 1'b1; in_data = 17'h003FF;
    tick;
    in_valid = 1'b0;
    chk("lat_not_early", 32'(out_valid), 32'd0);
    tick;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("noload_data", 32'(out_data), 32'h00000);
    tick;

    for (int i = 0; i < 9; i++) run_vec(vecs[i].w, vecs[i].d, vecs[i].ec, vecs[i].ef);

    // Rejected weight code and malformed sample.
    w_load = 1'b1; w_in = 17'h000FF;
    tick;
    w_in = 17'h000F0;
    tick;
    w_load = 1'b0;
    chk("w_err_pulse", {30'd0, w_err, w_err_f}, 32'd3);
    chk("w_err_keep_weight", 32'(weight_q), 32'h000FF);
    chk("w_err_keep_weight_f", 32'(weight_q_f), 32'h000FF);
    tick;
    chk("w_err_one_cycle", 32'(w_err), 32'd0);
    in_valid = 1'b1; in_data = 17'h00005;
    tick;
    in_valid = 1'b0;
    chk("in_err_pulse", {30'd0, in_err, in_err_f}, 32'd3);
    tick;
    chk("in_err_one_cycle", 32'(in_err), 32'd0);
    chk("in_err_valid", 32'(out_valid), 32'd1);
    chk("in_err_lvl1_ceil", 32'(out_data), 32'h00001);
    chk("in_err_lvl1_floor", 32'(out_data_f), 32'h00000);
    tick;

    // Back-pressure: two accepts fill the pipe, output held while stalled.
    w_load = 1'b1; w_in = 17'h0FFFF;
    tick;
    w_load = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 17'h00001;
    chk("stall_ready_1", 32'(in_ready), 32'd1);
    tick;
    in_data = 17'h00003;
    chk("stall_ready_2", 32'(in_ready), 32'd1);
    tick;
    in_data = 17'h00007;
    chk("stall_ready_low", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("stall_hold_ready", 32'(in_ready), 32'd0);
      chk("stall_hold_data", {14'd0, out_valid, out_data}, {14'd0, 1'b1, 17'h00001});
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", 32'(in_ready), 32'd1);
    collect("stall_order", 3, 1'b1, 17'h00001, 17'h00003, 17'h00007);

    // Weight load on the same edge as a sample acceptance.
    in_valid = 1'b1; in_data = 17'h0FFFF;
    w_load = 1'b1; w_in = 17'h000FF;
    tick;
    w_load = 1'b0;
    chk("same_edge_weight_q", 32'(weight_q), 32'h000FF);
    tick;
    in_valid = 1'b0;
    collect("same_edge_load", 2, 1'b0, 17'h0FFFF, 17'h000FF, 17'h00000);

    // Asynchronous reset with two samples in flight.
    w_load = 1'b1; w_in = 17'h0FFFF;
    tick;
    w_load = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 17'h00003;
    tick;
    in_data = 17'h00007;
    tick;
    in_valid = 1'b0;
    chk("inflight_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    chk("async_rst_weight", 32'(weight_q), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 17'h00003;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    tick;
    chk("post_rst_first_valid", 32'(out_valid), 32'd1);
    chk("post_rst_first_data", 32'(out_data), 32'h00000);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end
    run_vec(17'h0FFFF, 17'h00003, 17'h00003, 17'h00003);
    tick;
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
